// File: rtl/mult_dispatcher.sv
// Operand-pair FIFO front-end for the sequential shift-add multiplier: issues one pair at a
// time, waits for the result with a hang timeout, and returns products on a valid/ready stream.
module mult_dispatcher #(
  parameter int unsigned FIFO_DEPTH = 4,
  parameter int unsigned TIMEOUT    = 63
) (
  input  logic                          CLK,
  input  logic                          RST,
  input  logic                          IN_VALID_i,
  output logic                          IN_READY_o,
  input  logic [31:0]                   IN_A_i,
  input  logic [31:0]                   IN_B_i,
  output logic                          OUT_VALID_o,
  input  logic                          OUT_READY_i,
  output logic [63:0]                   OUT_PROD_o,
  output logic                          MUL_EN_o,
  output logic [31:0]                   MUL_DIN1_o,
  output logic [31:0]                   MUL_DIN2_o,
  input  logic                          MUL_BUSY_i,
  input  logic                          MUL_VALID_i,
  input  logic [63:0]                   MUL_DOUT_i,
  output logic [$clog2(FIFO_DEPTH):0]   LEVEL_o,
  output logic                          ERR_o
);

  localparam int unsigned AW      = $clog2(FIFO_DEPTH);
  localparam logic [AW:0] DEPTH_L = (AW + 1)'(FIFO_DEPTH);
  localparam logic [7:0]  TMO_L   = 8'(TIMEOUT);

  typedef enum logic [2:0] {StIdle, StIssue, StWaitBusy, StWaitDone, StOut} state_e;

  state_e        r_state;
  logic [31:0]   r_mem_a [FIFO_DEPTH];
  logic [31:0]   r_mem_b [FIFO_DEPTH];
  logic [AW-1:0] r_wptr;
  logic [AW-1:0] r_rptr;
  logic [AW:0]   r_level;
  logic [7:0]    r_tmo;
  logic [31:0]   r_din1;
  logic [31:0]   r_din2;
  logic          r_en;
  logic          r_out_valid;
  logic [63:0]   r_prod;
  logic          r_err;

  logic w_push;
  logic w_pop;

  assign IN_READY_o  = (r_level < DEPTH_L);
  assign w_push      = IN_VALID_i & IN_READY_o;
  assign w_pop       = (r_state == StIdle) && (r_level != '0);

  assign LEVEL_o     = r_level;
  assign MUL_EN_o    = r_en;
  assign MUL_DIN1_o  = r_din1;
  assign MUL_DIN2_o  = r_din2;
  assign OUT_VALID_o = r_out_valid;
  assign OUT_PROD_o  = r_prod;
  assign ERR_o       = r_err;

  always_ff @(posedge CLK) begin
    if (RST) begin
      r_wptr  <= '0;
      r_rptr  <= '0;
      r_level <= '0;
    end else begin
      if (w_push) r_wptr <= r_wptr + 1'b1;
      if (w_pop)  r_rptr <= r_rptr + 1'b1;
      if (w_push && !w_pop) begin
        r_level <= r_level + 1'b1;
      end else if (!w_push && w_pop) begin
        r_level <= r_level - 1'b1;
      end
    end
  end

  // Storage needs no reset: only entries below the level are ever read.
  always_ff @(posedge CLK) begin
    if (w_push) begin
      r_mem_a[r_wptr] <= IN_A_i;
      r_mem_b[r_wptr] <= IN_B_i;
    end
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      r_state     <= StIdle;
      r_en        <= 1'b0;
      r_din1      <= '0;
      r_din2      <= '0;
      r_tmo       <= '0;
      r_out_valid <= 1'b0;
      r_prod      <= '0;
      r_err       <= 1'b0;
    end else begin
      r_en <= 1'b0;
      unique case (r_state)
        StIdle: begin
          if (w_pop) begin
            r_din1  <= r_mem_a[r_rptr];
            r_din2  <= r_mem_b[r_rptr];
            r_en    <= 1'b1;
            r_state <= StIssue;
          end
        end
        StIssue: begin
          r_tmo   <= '0;
          r_state <= StWaitBusy;
        end
        // MUL_VALID_i is still high from the previous product here, so only BUSY matters.
        StWaitBusy: begin
          if (r_tmo == TMO_L) begin
            r_err   <= 1'b1;
            r_state <= StIdle;
          end else begin
            r_tmo <= r_tmo + 1'b1;
            if (MUL_BUSY_i) r_state <= StWaitDone;
          end
        end
        StWaitDone: begin
          if (MUL_VALID_i && !MUL_BUSY_i) begin
            r_prod      <= MUL_DOUT_i;
            r_out_valid <= 1'b1;
            r_state     <= StOut;
          end else if (r_tmo == TMO_L) begin
            r_err   <= 1'b1;
            r_state <= StIdle;
          end else begin
            r_tmo <= r_tmo + 1'b1;
          end
        end
        StOut: begin
          if (OUT_READY_i) begin
            r_out_valid <= 1'b0;
            r_state     <= StIdle;
          end
        end
        default: r_state <= StIdle;
      endcase
    end
  end

endmodule

// File: tb/tb_mult_dispatcher.sv
// Bench for mult_dispatcher: behavioural multiplier stub plus a queue-based reference model
// of issue order and products, driven by directed steps and a randomized stream.
module tb_mult_dispatcher;

  localparam int unsigned FIFO_DEPTH = 4;
  localparam int unsigned TIMEOUT    = 63;

  logic        CLK = 1'b0;
  logic        RST = 1'b1;
  logic        IN_VALID_i;
  logic        IN_READY_o;
  logic [31:0] IN_A_i;
  logic [31:0] IN_B_i;
  logic        OUT_VALID_o;
  logic        OUT_READY_i;
  logic [63:0] OUT_PROD_o;
  logic        MUL_EN_o;
  logic [31:0] MUL_DIN1_o;
  logic [31:0] MUL_DIN2_o;
  logic        MUL_BUSY_i;
  logic        MUL_VALID_i;
  logic [63:0] MUL_DOUT_i;
  logic [2:0]  LEVEL_o;
  logic        ERR_o;

  mult_dispatcher #(.FIFO_DEPTH(FIFO_DEPTH), .TIMEOUT(TIMEOUT)) dut (
    .CLK         (CLK),
    .RST         (RST),
    .IN_VALID_i  (IN_VALID_i),
    .IN_READY_o  (IN_READY_o),
    .IN_A_i      (IN_A_i),
    .IN_B_i      (IN_B_i),
    .OUT_VALID_o (OUT_VALID_o),
    .OUT_READY_i (OUT_READY_i),
    .OUT_PROD_o  (OUT_PROD_o),
    .MUL_EN_o    (MUL_EN_o),
    .MUL_DIN1_o  (MUL_DIN1_o),
    .MUL_DIN2_o  (MUL_DIN2_o),
    .MUL_BUSY_i  (MUL_BUSY_i),
    .MUL_VALID_i (MUL_VALID_i),
    .MUL_DOUT_i  (MUL_DOUT_i),
    .LEVEL_o     (LEVEL_o),
    .ERR_o       (ERR_o)
  );

  always #5 CLK = ~CLK;

  int checks = 0;
  int errors = 0;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed 0x%h expected 0x%h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  // Multiplier stub: BUSY rises 1-3 cycles after EN, VALID stays high (stale) until a result.
  logic        stub_dead = 1'b0;
  int unsigned lat_min   = 1;
  int unsigned lat_max   = 30;
  logic        s_pending;
  int unsigned s_dly;
  int unsigned s_cnt;
  logic [31:0] s_a;
  logic [31:0] s_b;

  always @(posedge CLK) begin
    if (RST) begin
      MUL_BUSY_i  <= 1'b0;
      MUL_VALID_i <= 1'b0;
      MUL_DOUT_i  <= '0;
      s_pending   <= 1'b0;
    end else if (MUL_EN_o) begin
      if (!stub_dead) begin
        s_pending <= 1'b1;
        s_dly     <= $urandom_range(2, 0);
        s_cnt     <= $urandom_range(lat_max, lat_min);
        s_a       <= MUL_DIN1_o;
        s_b       <= MUL_DIN2_o;
      end
    end else if (s_pending) begin
      if (s_dly == 0) begin
        s_pending  <= 1'b0;
        MUL_BUSY_i <= 1'b1;
      end else begin
        s_dly <= s_dly - 1;
      end
    end else if (MUL_BUSY_i) begin
      if (s_cnt == 0) begin
        MUL_BUSY_i  <= 1'b0;
        MUL_VALID_i <= 1'b1;
        MUL_DOUT_i  <= 64'(s_a) * 64'(s_b);
      end else begin
        s_cnt <= s_cnt - 1;
      end
    end
  end

  // Reference model: accepted pairs in order; products of issued pairs awaiting output.
  logic [31:0] q_a[$];
  logic [31:0] q_b[$];
  logic [63:0] q_prod[$];
  int          en_count  = 0;
  int          out_count = 0;

  initial begin
    logic prev_en;
    logic [31:0] ea;
    logic [31:0] eb;
    prev_en = 1'b0;
    forever begin
      @(negedge CLK);
      if (RST) begin
        q_a.delete();
        q_b.delete();
        q_prod.delete();
        prev_en = 1'b0;
      end else begin
        if (IN_VALID_i && IN_READY_o) begin
          q_a.push_back(IN_A_i);
          q_b.push_back(IN_B_i);
        end
        if (MUL_EN_o) begin
          en_count++;
          check("en_not_back_to_back", 64'(prev_en), 64'(0));
          check("one_outstanding", 64'(q_prod.size()), 64'(0));
          check("issue_has_pair", 64'(q_a.size() != 0), 64'(1));
          if (q_a.size() != 0) begin
            ea = q_a.pop_front();
            eb = q_b.pop_front();
            check("din1", 64'(MUL_DIN1_o), 64'(ea));
            check("din2", 64'(MUL_DIN2_o), 64'(eb));
            if (!stub_dead) q_prod.push_back(64'(ea) * 64'(eb));
          end
        end
        prev_en = MUL_EN_o;
        if (OUT_VALID_o && OUT_READY_i) begin
          out_count++;
          check("out_expected", 64'(q_prod.size() != 0), 64'(1));
          if (q_prod.size() != 0) check("prod_in_order", OUT_PROD_o, q_prod.pop_front());
        end
      end
    end
  end

  task automatic push(input logic [31:0] a, input logic [31:0] b);
    int n;
    n = 0;
    IN_VALID_i = 1'b1;
    IN_A_i     = a;
    IN_B_i     = b;
    while (!IN_READY_o && n < 300) begin
      tick();
      n++;
    end
    check("push_ready_in_time", 64'(n < 300), 64'(1));
    tick();
    IN_VALID_i = 1'b0;
  endtask

  task automatic wait_out(input string tag, output logic [63:0] prod);
    int n;
    n = 0;
    while (!OUT_VALID_o && n < 300) begin
      tick();
      n++;
    end
    check({tag, "_valid"}, 64'(OUT_VALID_o), 64'(1));
    prod = OUT_PROD_o;
  endtask

  initial begin
    logic [63:0] p;
    logic [63:0] first;
    logic [31:0] ta [6];
    logic [31:0] tb [6];
    int          n;
    int          en0;
    int          o0;
    int          sent;
    logic        acc;

    IN_VALID_i  = 1'b0;
    IN_A_i      = '0;
    IN_B_i      = '0;
    OUT_READY_i = 1'b1;
    RST         = 1'b1;
    repeat (3) tick();
    check("rst_level", 64'(LEVEL_o), 64'(0));
    check("rst_in_ready", 64'(IN_READY_o), 64'(1));
    check("rst_out_valid", 64'(OUT_VALID_o), 64'(0));
    check("rst_out_prod", OUT_PROD_o, 64'(0));
    check("rst_mul_en", 64'(MUL_EN_o), 64'(0));
    check("rst_din1", 64'(MUL_DIN1_o), 64'(0));
    check("rst_din2", 64'(MUL_DIN2_o), 64'(0));
    check("rst_err", 64'(ERR_o), 64'(0));
    RST = 1'b0;
    tick();

    // Single 3*5.
    en0 = en_count;
    push(32'd3, 32'd5);
    wait_out("t1", p);
    check("t1_prod", p, 64'h0000_0000_0000_000F);
    tick();
    check("t1_one_en", 64'(en_count - en0), 64'(1));
    check("t1_din1_held", 64'(MUL_DIN1_o), 64'(3));
    check("t1_din2_held", 64'(MUL_DIN2_o), 64'(5));
    check("t1_err", 64'(ERR_o), 64'(0));

    // Back-to-back extremes.
    push(32'hFFFF_FFFF, 32'hFFFF_FFFF);
    push(32'h0, 32'h1234_5678);
    wait_out("t2a", p);
    check("t2a_prod", p, 64'hFFFF_FFFE_0000_0001);
    tick();
    wait_out("t2b", p);
    check("t2b_prod", p, 64'h0);
    tick();

    // Back-pressure: fill FIFO while the first product is held.
    OUT_READY_i = 1'b0;
    for (int i = 0; i < 6; i++) begin
      ta[i] = $urandom;
      tb[i] = $urandom;
    end
    for (int i = 0; i < 5; i++) push(ta[i], tb[i]);
    IN_VALID_i = 1'b1;
    IN_A_i     = ta[5];
    IN_B_i     = tb[5];
    repeat (80) tick();
    first = 64'(ta[0]) * 64'(tb[0]);
    check("t3_in_ready_low", 64'(IN_READY_o), 64'(0));
    check("t3_level_full", 64'(LEVEL_o), 64'(4));
    check("t3_out_valid", 64'(OUT_VALID_o), 64'(1));
    for (int i = 0; i < 3; i++) begin
      check("t3_prod_held", OUT_PROD_o, first);
      tick();
    end
    IN_VALID_i  = 1'b0;
    OUT_READY_i = 1'b1;
    o0 = out_count;
    n  = 0;
    while (out_count - o0 < 5 && n < 1000) begin
      tick();
      n++;
    end
    repeat (20) tick();
    check("t3_five_out", 64'(out_count - o0), 64'(5));
    check("t3_model_drained", 64'(q_prod.size() + q_a.size()), 64'(0));

    // Hung multiplier: timeout, then recovery.
    stub_dead = 1'b1;
    push(32'd7, 32'd9);
    n = 0;
    while (!MUL_EN_o && n < 50) begin
      tick();
      n++;
    end
    check("t4_issued", 64'(MUL_EN_o), 64'(1));
    n = 0;
    while (!ERR_o && n < 200) begin
      tick();
      n++;
    end
    check("t4_timeout_cycles", 64'(n), 64'(TIMEOUT + 2));
    check("t4_err", 64'(ERR_o), 64'(1));
    check("t4_no_out", 64'(OUT_VALID_o), 64'(0));
    stub_dead = 1'b0;
    ta[0] = $urandom;
    tb[0] = $urandom;
    push(ta[0], tb[0]);
    wait_out("t4_next", p);
    check("t4_next_prod", p, 64'(ta[0]) * 64'(tb[0]));
    tick();
    check("t4_err_sticky", 64'(ERR_o), 64'(1));

    // Reset while waiting for the result.
    lat_min = 25;
    lat_max = 25;
    push(32'd11, 32'd13);
    n = 0;
    while (!MUL_BUSY_i && n < 50) begin
      tick();
      n++;
    end
    check("t5_busy_seen", 64'(MUL_BUSY_i), 64'(1));
    tick();
    RST = 1'b1;
    tick();
    RST = 1'b0;
    check("t5_out_valid", 64'(OUT_VALID_o), 64'(0));
    check("t5_level", 64'(LEVEL_o), 64'(0));
    check("t5_mul_en", 64'(MUL_EN_o), 64'(0));
    check("t5_err_cleared", 64'(ERR_o), 64'(0));
    lat_min = 1;
    lat_max = 30;
    push(32'd2, 32'd21);
    wait_out("t5_fresh", p);
    check("t5_fresh_prod", p, 64'd42);
    tick();

    // Randomized stream against the model.
    o0   = out_count;
    sent = 0;
    n    = 0;
    IN_VALID_i = 1'b0;
    while (sent < 200 && n < 30000) begin
      @(negedge CLK);
      acc = IN_VALID_i && IN_READY_o;
      tick();
      n++;
      if (acc) sent++;
      if (acc || !IN_VALID_i) begin
        IN_VALID_i = ($urandom_range(3, 0) != 0) && (sent < 200);
        IN_A_i     = $urandom;
        IN_B_i     = $urandom;
      end
      OUT_READY_i = 1'($urandom_range(1, 0));
    end
    IN_VALID_i  = 1'b0;
    OUT_READY_i = 1'b1;
    check("t6_all_sent", 64'(sent), 64'(200));
    n = 0;
    while (out_count - o0 < 200 && n < 5000) begin
      tick();
      n++;
    end
    repeat (5) tick();
    check("t6_all_out", 64'(out_count - o0), 64'(200));
    check("t6_model_drained", 64'(q_prod.size() + q_a.size()), 64'(0));
    check("t6_no_err", 64'(ERR_o), 64'(0));

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
